store_hash_tracker: RTL

//  In-order tracker of in-flight store address hashes (4-bit, from the LSU address hash).
//  - Sits downstream of the hash stage.
//  - Each issued load's hash is compared against all pending stores.
//  - Produces a registered conflict flag and mask; the LSU uses them to hold or forward.
//  - Entries are freed in order as stores commit.

---
 rtl/store_hash_tracker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/store_hash_tracker.sv
// store_hash_tracker: in-order tracker of in-flight store address hashes.
// A DEPTH-entry circular buffer of {valid, hash} is allocated at the tail
// by stores and freed at the head as stores commit. Each load_check
// compares load_hash against every valid entry on pre-edge state. The
// conflict flag and mask are registered, so results appear one cycle later.
// Optional feature macro: STORE_HASH_YOUNGEST_EN. When it is defined,
// youngest_idx reports the matching slot nearest tail-1. When it is not
// defined, youngest_idx is tied to 0.
module store_hash_tracker #(
  parameter int DEPTH  = 4,
  parameter int HASH_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       store_push,
  input  logic [HASH_W-1:0]          store_hash,
  input  logic                       store_pop,
  input  logic                       load_check,
  input  logic [HASH_W-1:0]          load_hash,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       conflict_valid,
  output logic                       conflict,
  output logic [DEPTH-1:0]           conflict_mask,
  output logic [$clog2(DEPTH)-1:0]   youngest_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [HASH_W-1:0] hash_q [DEPTH];
  logic [HASH_W-1:0] hash_d [DEPTH];
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              conflict_valid_q, conflict_valid_d;
  logic              conflict_q, conflict_d;
  logic [DEPTH-1:0]  conflict_mask_q, conflict_mask_d;

  logic [DEPTH-1:0]  match;
  logic              push_ok;
  logic              pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
  assign push_ok = store_push & (~full | store_pop);
  assign pop_ok  = store_pop & ~empty;

  // Per-slot compare against pre-edge contents.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (hash_q[i] == load_hash);
    end
  end

  // Next-state for buffer, pointers, occupancy and the check result.
  always_comb begin
    valid_d = valid_q;
    hash_d  = hash_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // The pop is applied before the push, so push+pop on a full buffer
      // (head == tail) leaves the reused slot valid.
      if (pop_ok) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (push_ok) begin
        valid_d[tail_q] = 1'b1;
        hash_d[tail_q]  = store_hash;
        tail_d          = tail_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    conflict_valid_d = load_check & ~flush;
    conflict_d       = conflict_valid_d & (|match);
    conflict_mask_d  = conflict_valid_d ? match : '0;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      conflict_valid_q <= 1'b0;
      conflict_q       <= 1'b0;
      conflict_mask_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) hash_q[i] <= '0;
    end else begin
      valid_q          <= valid_d;
      hash_q           <= hash_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      conflict_valid_q <= conflict_valid_d;
      conflict_q       <= conflict_d;
      conflict_mask_q  <= conflict_mask_d;
    end
  end

  assign conflict_valid = conflict_valid_q;
  assign conflict       = conflict_q;
  assign conflict_mask  = conflict_mask_q;

`ifdef STORE_HASH_YOUNGEST_EN
  logic [AW-1:0] youngest_q, youngest_d;
  logic [AW-1:0] slot;
  logic          found;

  // Backward search from tail-1 with wrap; the first match is the youngest store.
  always_comb begin
    youngest_d = '0;
    slot       = '0;
    found      = 1'b0;
    if (conflict_valid_d) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slot = tail_q - AW'(k + 1);
        if (!found && match[slot]) begin
          found      = 1'b1;
          youngest_d = slot;
        end
      end
    end
  end

  // Youngest-match register, aligned with conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) youngest_q <= '0;
    else        youngest_q <= youngest_d;
  end

  assign youngest_idx = youngest_q;
`else
  assign youngest_idx = '0;
`endif

endmodule
